uart_tx_buffered: RTL
=====================

// Module: uart_tx_buffered
// PURPOSE
//  Buffered 8N1 serial transmitter for the FTDI TxD line (FTDI_BD1) on marsohod2bis.
//  Host-side logic pushes bytes into an internal FIFO; the block serialises them back-to-back.
//  Honours the FTDI RTS line (FTDI_BD2) as a clear-to-send gate.
//  Complements the serial receiver, so fabric logic can emit bursts without tracking busy per byte.
// PARAMETERS
//  CLK_HZ   12000000  frequency of clk100 in Hz (PLL c0 output)
//  BAUD     115200    line rate; DIV = (CLK_HZ + BAUD/2) / BAUD cycles per bit (104 at defaults)
//  FIFO_AW  3         FIFO address width; depth = 2**FIFO_AW (8)
// PORTS
//  clk100   in   1  system clock; all logic on rising edge
//  reset    in   1  synchronous, active-high reset
//  wr_byte  in   8  byte to enqueue
//  wr_en    in   1  enqueue strobe, one byte per cycle while high
//  full     out  1  FIFO full; writes while high are dropped
//  empty    out  1  FIFO empty
//  cts_n    in   1  async from FTDI RTS; 0 = host ready to receive
//  tx       out  1  serial output, idle high, registered
//  busy     out  1  high while a frame is on the line (START..STOP)
// BEHAVIOUR
//  Reset values: tx=1, busy=0, full=0, empty=1, FIFO pointers=0, FSM=IDLE, CTS sync flops=1.
//  FIFO write rule:
//   - wr_en && !full writes wr_byte; full/empty are registered.
//   - A write in the same cycle as a pop on a full FIFO is still dropped (full gates writes).
//  FIFO read:
//   - Pop only from FSM IDLE or STOP-end.
//   - A byte written at cycle N into an empty FIFO is visible (empty=0) at N+1.
//  CTS: cts_n passes through a 2-flop synchronizer (cts_s).
//   - Sampled only when deciding to start a frame; a frame in progress always completes.
//  FSM states:
//   - IDLE: if !empty && cts_s==0 -> pop, load shift reg, tx<=0, busy<=1, bit counter=0 -> START.
//   - START: hold tx=0 for DIV cycles -> DATA.
//   - DATA: 8 bits, LSB first, DIV cycles each; 3-bit bit index wraps 7->0 on exit -> STOP.
//   - STOP: tx=1 for DIV cycles. At the end, if !empty && cts_s==0, pop and go straight to START
//     (no idle gap); else busy<=0 -> IDLE.
//  Latency: wr_en at N into empty FIFO, idle, cts_s=0 -> tx falls at edge N+2.
//  Frame length is exactly 10*DIV cycles; the baud counter is [$clog2(DIV)-1:0] and reloads at every bit boundary.
//  Simultaneous wr_en and pop on an empty-then-nonempty FIFO are legal; the count stays consistent.
//  Reset mid-frame: tx=1 the next cycle, FIFO flushed, partial frame abandoned.
//  cts_n deasserts mid-frame: the frame finishes; the next byte waits in IDLE with tx=1.
// STRUCTURE
//  Include file uart_defs.vh holds:
//   - FSM state encodings (IDLE/START/DATA/STOP, 2-bit)
//   - default CLK_HZ/BAUD
//   - the DIV rounding macro shared with the serial receiver
//  Sub-module tx_byte_fifo (params DW=8, AW=FIFO_AW):
//   - synchronous FIFO with ports clk100, reset, wr_en, wr_data, rd_en, rd_data, full, empty
//   - first-word rd_data valid combinationally from memory at the read pointer
//  Top level: FSM, baud counter, shift register, CTS synchronizer.
// TESTING (sim with CLK_HZ=1000, BAUD=100 -> DIV=10)
//  1. cts_n=0, write 8'h55 at cycle 10 -> tx low at 12; bits 1,0,1,0,1,0,1,0 each 10 cycles; stop high;
//     busy low at 112.
//  2. Write 8'hA1, 8'h00, 8'hFF on consecutive cycles -> three frames, no idle between, busy high for 300 cycles.
//  3. cts_n=1, write 9 bytes -> full=1 after 8th, 9th dropped, tx stays 1;
//     release cts_n -> 8 frames, then empty=1.
//  4. Raise cts_n during bit 3 of frame 1 of 2 -> frame 1 completes; frame 2 starts 3 cycles after cts_n=0.
//  5. Assert reset for 1 cycle mid-DATA -> tx=1, busy=0, empty=1 the next cycle; a new write transmits correctly.
//  6. Loopback tx into the serial receiver at default params -> 256 bytes 0..255 received in order, no errors.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered 8N1 transmitter: FSM encoding,
// default line parameters and the bit-period rounding helper.
package uart_tx_buffered_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int DEF_CLK_HZ = 12000000;
  localparam int DEF_BAUD   = 115200;

  // Clock cycles per bit, rounded to nearest; shared with the serial receiver.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Host-side byte write port of the buffered transmitter.
interface uart_tx_buffered_if;
  logic [7:0] wr_byte;
  logic       wr_en;
  logic       full;
  logic       empty;

  modport master (output wr_byte, output wr_en, input full, input empty);
  modport slave  (input wr_byte, input wr_en, output full, output empty);
endinterface

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous byte FIFO with registered full/empty flags and a
// first-word-fall-through read port.
module uart_tx_buffered_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk100,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          r_full, r_empty;
  logic [AW:0]   w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic          w_do_wr, w_do_rd;

  // Full gates writes even when a pop happens in the same cycle.
  assign w_do_wr      = wr_en && !r_full;
  assign w_do_rd      = rd_en && !r_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_do_wr};
  assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_do_rd};

  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign full    = r_full;
  assign empty   = r_empty;

  // Storage array, written only on accepted writes.
  always_ff @(posedge clk100) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointers and flags; flags are derived from the post-update pointers.
  always_ff @(posedge clk100) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_full   <= (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                  (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 transmitter: bytes queue in a FIFO and are sent back-to-back
// on tx while the synchronized clear-to-send input is low.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int BAUD    = DEF_BAUD,
  parameter int FIFO_AW = 3
) (
  input  logic                clk100,
  input  logic                reset,
  uart_tx_buffered_if.slave   wr,
  input  logic                cts_n,
  output logic                tx,
  output logic                busy
);
  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  tx_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_cts_s1, r_cts_s2;
  logic          w_pop, w_empty, w_can_start, w_bit_end;
  logic [7:0]    w_rd_data;

  uart_tx_buffered_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
    .clk100  (clk100),
    .reset   (reset),
    .wr_en   (wr.wr_en),
    .wr_data (wr.wr_byte),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (wr.full),
    .empty   (w_empty)
  );

  assign wr.empty = w_empty;
  assign tx       = r_tx;
  assign busy     = r_busy;

  // Two-flop synchronizer for the asynchronous clear-to-send input.
  always_ff @(posedge clk100) begin
    if (reset) begin
      r_cts_s1 <= 1'b1;
      r_cts_s2 <= 1'b1;
    end else begin
      r_cts_s1 <= cts_n;
      r_cts_s2 <= r_cts_s1;
    end
  end

  // State, baud counter, shift register and registered line outputs.
  always_ff @(posedge clk100) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Frame sequencing; CTS is only consulted when a new frame could start.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_pop       = 1'b0;
    w_can_start = !w_empty && !r_cts_s2;
    w_bit_end   = (r_cnt == C_LAST);
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt  = '0;
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (w_can_start) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rd_data;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_bit_nxt   = '0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          w_bit_nxt = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_STOP;
          end else begin
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (w_can_start) begin
            // Chain straight into the next frame without an idle bit.
            w_pop       = 1'b1;
            w_shift_nxt = w_rd_data;
            w_tx_nxt    = 1'b0;
            w_bit_nxt   = '0;
            w_state_nxt = ST_START;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
